// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: state encoding and ALU opcode constants shared by alu_arbiter and its users.
package alu_arb_pkg;
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;
   typedef enum logic [1:0] {S_IDLE = ST_IDLE, S_EXEC = ST_EXEC, S_RESP = ST_RESP} state_e;
   localparam logic [2:0] OP_ADD    = 3'd0;
   localparam logic [2:0] OP_SUB    = 3'd1;
   localparam logic [2:0] OP_AND    = 3'd2;
   localparam logic [2:0] OP_OR     = 3'd3;
   localparam logic [2:0] OP_XOR    = 3'd4;
   localparam logic [2:0] OP_SHL    = 3'd5;
   localparam logic [2:0] OP_PASSB  = 3'd6;
   localparam logic [2:0] OP_PASSA2 = 3'd7;
endpackage

// File: rtl/alu_arbiter_rr_grant.sv
// rr_grant: combinational round-robin priority encoder; the first request at or after ptr_i wins.
module rr_grant #(
   parameter int N = 2,
   parameter int W = 1
) (
   input  logic [N-1:0] req_i,
   input  logic [W-1:0] ptr_i,
   output logic [N-1:0] gnt_o,
   output logic [W-1:0] idx_o
);
   int j;
   // Walk from farthest to nearest so the closest request to ptr_i overwrites the others.
   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      j = 0;
      for (int k = N - 1; k >= 0; k--) begin
         j = (int'(ptr_i) + k) % N;
         if (|(req_i & (N'(1) << j))) begin
            gnt_o = N'(1) << j;
            idx_o = W'(j);
         end
      end
   end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU among NREQ requesters, one op in flight.
// Optional ALU_ARB_STATS_EN adds saturating busy_cnt/ops_cnt outputs.
module alu_arbiter
   import alu_arb_pkg::*;
#(
   parameter int NBITS = 15,
   parameter int NREQ  = 2,
   parameter int IDW   = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NREQ-1:0]           req_valid,
   output logic [NREQ-1:0]           req_ready,
   input  logic [NREQ*(NBITS+1)-1:0] req_a,
   input  logic [NREQ*(NBITS+1)-1:0] req_b,
   input  logic [NREQ*3-1:0]         req_op,
   output logic [NBITS:0]            alu_a,
   output logic [NBITS:0]            alu_b,
   output logic [2:0]                alu_opcode,
   input  logic [NBITS+1:0]          alu_y,
   input  logic                      alu_co,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [NBITS+1:0]          rsp_y,
   output logic                      rsp_co,
   output logic [IDW-1:0]            rsp_id
`ifdef ALU_ARB_STATS_EN
   ,
   output logic [31:0]               busy_cnt,
   output logic [31:0]               ops_cnt
`endif
);
   localparam int W = NBITS + 1;
   state_e state_q, state_d;
   logic [IDW-1:0] ptr_q, ptr_d, idx, id_q;
   logic [NREQ-1:0] gnt;
   logic hs;
   logic [W-1:0] a_q, b_q;
   logic [2:0] op_q;
   logic [NBITS+1:0] y_q;
   logic co_q;
   rr_grant #(.N(NREQ), .W(IDW)) u_grant (
      .req_i(req_valid),
      .ptr_i(ptr_q),
      .gnt_o(gnt),
      .idx_o(idx)
   );
   always_comb begin
      hs = (state_q == S_IDLE) && |req_valid;
      state_d = (state_q == S_IDLE) ? (hs ? S_EXEC : S_IDLE) :
                (state_q == S_EXEC) ? S_RESP :
                (state_q == S_RESP && !rsp_ready) ? S_RESP : S_IDLE;
      ptr_d = hs ? ((idx == IDW'(NREQ - 1)) ? '0 : idx + 1'b1) : ptr_q;
      req_ready = hs ? gnt : '0;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         id_q    <= '0;
         y_q     <= '0;
         co_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         if (hs) begin
            a_q  <= req_a[int'(idx)*W +: W];
            b_q  <= req_b[int'(idx)*W +: W];
            op_q <= req_op[int'(idx)*3 +: 3];
            id_q <= idx;
         end
         // The ALU result has settled by the end of EXEC.
         if (state_q == S_EXEC) begin
            y_q  <= alu_y;
            co_q <= alu_co;
         end
      end
   end
   assign alu_a      = a_q;
   assign alu_b      = b_q;
   assign alu_opcode = op_q;
   assign rsp_valid  = (state_q == S_RESP);
   assign rsp_y      = y_q;
   assign rsp_co     = co_q;
   assign rsp_id     = id_q;
`ifdef ALU_ARB_STATS_EN
   logic [31:0] busy_q, ops_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= '0;
         ops_q  <= '0;
      end else begin
         if (state_q != S_IDLE && !(&busy_q)) busy_q <= busy_q + 32'd1;
         if (rsp_valid && rsp_ready && !(&ops_q)) ops_q <= ops_q + 32'd1;
      end
   end
   assign busy_cnt = busy_q;
   assign ops_cnt  = ops_q;
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed bench for alu_arbiter with a behavioural ALU driving alu_y/alu_co.
module tb_alu_arbiter;
   localparam int NB = 15;
   localparam int NR = 2;
   localparam int IW = 1;
   localparam int W  = NB + 1;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [NR-1:0] req_valid = '0;
   logic [NR-1:0] req_ready;
   logic [NR*W-1:0] req_a = '0;
   logic [NR*W-1:0] req_b = '0;
   logic [NR*3-1:0] req_op = '0;
   logic [NB:0] alu_a, alu_b;
   logic [2:0] alu_opcode;
   logic [NB+1:0] alu_y;
   logic alu_co;
   logic rsp_valid;
   logic rsp_ready = 1'b1;
   logic [NB+1:0] rsp_y;
   logic rsp_co;
   logic [IW-1:0] rsp_id;
`ifdef ALU_ARB_STATS_EN
   logic [31:0] busy_cnt, ops_cnt;
`endif
   int n_tests = 0;
   int n_fail = 0;
   int cyc = 0;
   alu_arbiter #(.NBITS(NB), .NREQ(NR), .IDW(IW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_op(req_op),
      .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
      .alu_y(alu_y), .alu_co(alu_co),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_y(rsp_y), .rsp_co(rsp_co), .rsp_id(rsp_id)
`ifdef ALU_ARB_STATS_EN
      , .busy_cnt(busy_cnt), .ops_cnt(ops_cnt)
`endif
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   // Signed 17-bit ALU; carry is the unsigned carry/borrow for add/sub, else the result MSB.
   function automatic logic [17:0] alu_model(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
      logic [16:0] sa, sb, y, u;
      logic co;
      sa = {a[15], a};
      sb = {b[15], b};
      u = {1'b0, a} + {1'b0, b};
      y = (op == 3'd0) ? sa + sb : (op == 3'd1) ? sa - sb : (op == 3'd2) ? sa & sb :
          (op == 3'd3) ? sa | sb : (op == 3'd4) ? sa ^ sb : (op == 3'd5) ? sa << 1 :
          (op == 3'd6) ? sb : sa;
      co = (op == 3'd0) ? u[16] : (op == 3'd1) ? (a < b) : y[16];
      return {co, y};
   endfunction
   always_comb {alu_co, alu_y} = alu_model(alu_a, alu_b, alu_opcode);
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
      req_a[i*W +: W] = a;
      req_b[i*W +: W] = b;
      req_op[i*3 +: 3] = op;
      req_valid[i] = 1'b1;
   endtask
   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask
   task automatic wait_rsp(input string tag, input int id, input logic [16:0] y, input logic co);
      int n;
      n = 0;
      while (!rsp_valid && n < 10) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_valid"}, rsp_valid, 1);
      check({tag, "_y"}, rsp_y, y);
      check({tag, "_co"}, rsp_co, co);
      check({tag, "_id"}, rsp_id, id);
      @(negedge clk);
   endtask
   task automatic do_op(input string tag, input int i, input logic [15:0] a, input logic [15:0] b,
                        input logic [2:0] op, input logic [16:0] y, input logic co);
      int n;
      set_req(i, a, b, op);
      #1;
      n = 0;
      while (!req_ready[i] && n < 10) begin
         @(negedge clk);
         #1;
         n++;
      end
      check({tag, "_grant"}, req_ready[i], 1);
      @(negedge clk);
      req_valid[i] = 1'b0;
      wait_rsp(tag, i, y, co);
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      int t_prev;
      int n;
      @(negedge clk);
      @(negedge clk);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_req_ready", req_ready, 0);
      check("rst_alu_a", alu_a, 0);
      check("rst_alu_b", alu_b, 0);
      check("rst_alu_op", alu_opcode, 0);
      check("rst_rsp_y", rsp_y, 0);
      check("rst_rsp_id", rsp_id, 0);
      rst = 1'b0;
      // Single request with exact cycle-by-cycle timing.
      set_req(0, 16'd5, 16'd3, 3'd0);
      #1;
      check("t1_ready", req_ready, 2'b01);
      @(negedge clk);
      req_valid = '0;
      check("t1_alu_a", alu_a, 5);
      check("t1_alu_b", alu_b, 3);
      check("t1_alu_op", alu_opcode, 0);
      check("t1_exec_valid", rsp_valid, 0);
      check("t1_exec_ready", req_ready, 0);
      @(negedge clk);
      check("t1_valid", rsp_valid, 1);
      check("t1_y", rsp_y, 8);
      check("t1_co", rsp_co, 0);
      check("t1_id", rsp_id, 0);
      @(negedge clk);
      check("t1_done", rsp_valid, 0);
      check("t1_hold_a", alu_a, 5);
      // Contention from ptr=0: grants alternate 0,1,0,1 at one op per 3 cycles.
      do_reset();
      set_req(0, 16'd1, 16'd1, 3'd0);
      set_req(1, 16'd2, 16'd2, 3'd0);
      t_prev = 0;
      for (int k = 0; k < 4; k++) begin
         n = 0;
         while (!rsp_valid && n < 10) begin
            @(negedge clk);
            n++;
         end
         check("t2_valid", rsp_valid, 1);
         check("t2_id", rsp_id, k % 2);
         check("t2_y", rsp_y, (k % 2) ? 4 : 2);
         if (k > 0) check("t2_gap", cyc - t_prev, 3);
         t_prev = cyc;
         if (k == 3) req_valid = '0;
         @(negedge clk);
      end
      // Backpressure: five RESP cycles with rsp_ready low, then accept and grant requester 1.
      rsp_ready = 1'b0;
      set_req(0, 16'd10, 16'd20, 3'd0);
      set_req(1, 16'd7, 16'd3, 3'd4);
      #1;
      check("t3_gnt0", req_ready, 2'b01);
      @(negedge clk);
      req_valid[0] = 1'b0;
      check("t3_exec_ready", req_ready, 0);
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         check("t3_bp_valid", rsp_valid, 1);
         check("t3_bp_y", rsp_y, 30);
         check("t3_bp_id", rsp_id, 0);
         check("t3_bp_ready", req_ready, 0);
         @(negedge clk);
      end
      check("t3_hold_y", rsp_y, 30);
      rsp_ready = 1'b1;
      @(negedge clk);
      #1;
      check("t3_next_gnt", req_ready, 2'b10);
      @(negedge clk);
      req_valid[1] = 1'b0;
      wait_rsp("t3_r1", 1, 17'd4, 1'b0);
      // Wide results pass through untruncated.
      do_op("t4_sub", 0, 16'h7FFF, 16'h7FFF, 3'd1, 17'h00000, 1'b0);
      do_op("t4_neg", 0, 16'h8000, 16'h8000, 3'd0, 17'h10000, 1'b1);
      do_op("t4_pos", 1, 16'h7FFF, 16'h7FFF, 3'd0, 17'h0FFFE, 1'b0);
      // Reset in EXEC drops the op; ptr returns to 0.
      set_req(0, 16'd9, 16'd9, 3'd0);
      #1;
      check("t5_gnt", req_ready, 2'b01);
      @(negedge clk);
      req_valid = '0;
      rst = 1'b1;
      @(negedge clk);
      check("t5_valid", rsp_valid, 0);
      check("t5_alu_a", alu_a, 0);
      check("t5_alu_op", alu_opcode, 0);
      check("t5_rsp_y", rsp_y, 0);
      check("t5_rsp_id", rsp_id, 0);
      rst = 1'b0;
      @(negedge clk);
      check("t5_no_rsp", rsp_valid, 0);
      set_req(0, 16'd4, 16'd4, 3'd0);
      set_req(1, 16'd6, 16'd6, 3'd0);
      #1;
      check("t5_ptr0", req_ready, 2'b01);
      @(negedge clk);
      req_valid = '0;
      wait_rsp("t5_r", 0, 17'd8, 1'b0);
`ifdef ALU_ARB_STATS_EN
      do_reset();
      set_req(0, 16'd1, 16'd1, 3'd0);
      for (int k = 0; k < 4; k++) begin
         n = 0;
         while (!rsp_valid && n < 10) begin
            @(negedge clk);
            n++;
         end
         check("t6_valid", rsp_valid, 1);
         if (k == 3) req_valid = '0;
         @(negedge clk);
      end
      @(negedge clk);
      check("t6_ops", ops_cnt, 4);
      check("t6_busy", busy_cnt, 8);
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
